// File: rtl/fifo_pkt_reader.sv
// Read-side consumer for the synchronous FIFO: pops fixed-length packets and streams
// them out on valid/ready with SOP/EOP markers and an idle gap between packets.
module fifo_pkt_reader #(
  parameter int WIDTH   = 14,
  parameter int PKT_LEN = 16,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic [15:0]      pkt_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP} state_t;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q;
  logic [7:0]       word_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q;
  logic             m_sop_q;
  logic             m_eop_q;
  logic [15:0]      pkt_cnt_q;
  logic             pop;
  logic             accept;
  logic             last_word;

  // Pop is combinational so the FIFO's same-cycle read data lands in the output register.
  assign pop       = (state_q == S_READ) && !fifo_empty && (!m_valid_q || m_ready);
  assign accept    = m_valid_q && m_ready;
  assign last_word = (word_cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sop_q    <= 1'b0;
      m_eop_q    <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      if (accept && m_eop_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;

      if (pop) begin
        m_data_q  <= fifo_dout;
        m_valid_q <= 1'b1;
        m_sop_q   <= (word_cnt_q == 8'd0);
        m_eop_q   <= last_word;
      end else if (accept) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          word_cnt_q <= '0;
          if (!fifo_empty) state_q <= S_READ;
        end
        S_READ: begin
          if (pop) begin
            if (last_word) begin
              word_cnt_q <= '0;
              gap_cnt_q  <= GAP_LOAD;
              state_q    <= (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              word_cnt_q <= word_cnt_q + 8'd1;
            end
          end
        end
        S_GAP: begin
          gap_cnt_q <= gap_cnt_q - 4'd1;
          if (gap_cnt_q == 4'd0) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd_en = pop;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_sop      = m_sop_q;
  assign m_eop      = m_eop_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign busy       = (state_q != S_IDLE) || m_valid_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: FIFO models feed two instances (16-word/gap-2 and
// 1-word/gap-0); a stream scoreboard predicts data, SOP/EOP and packet counts.
module tb_fifo_pkt_reader;
  localparam int W     = 14;
  localparam int PL    = 16;
  localparam int GP    = 2;
  localparam int DEPTH = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: PKT_LEN=16, GAP=2
  logic [W-1:0] f_dout  = '0;
  logic         f_empty = 1'b1;
  logic         rd_en, m_valid, m_sop, m_eop, busy;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic [15:0]  pkt_cnt;

  // Instance 1: PKT_LEN=1, GAP=0
  logic [W-1:0] f_dout1  = '0;
  logic         f_empty1 = 1'b1;
  logic         rd_en1, m_valid1, m_sop1, m_eop1, busy1;
  logic         m_ready1 = 1'b1;
  logic [W-1:0] m_data1;
  logic [15:0]  pkt_cnt1;

  fifo_pkt_reader #(.WIDTH(W), .PKT_LEN(PL), .GAP(GP)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(f_dout), .fifo_empty(f_empty),
    .fifo_rd_en(rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .pkt_cnt(pkt_cnt), .busy(busy));

  fifo_pkt_reader #(.WIDTH(W), .PKT_LEN(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_dout(f_dout1), .fifo_empty(f_empty1),
    .fifo_rd_en(rd_en1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_sop(m_sop1), .m_eop(m_eop1), .pkt_cnt(pkt_cnt1), .busy(busy1));

  // FIFO models: storage written by the stimulus, read pointer advanced on pops.
  logic [W-1:0] mem0 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int nxt0, nxt1;
  assign nxt0 = rd0 + ((rd_en && !f_empty) ? 1 : 0);
  assign nxt1 = rd1 + ((rd_en1 && !f_empty1) ? 1 : 0);

  always @(posedge clk) begin
    rd0      <= nxt0;
    f_dout   <= mem0[12'(nxt0)];
    f_empty  <= (nxt0 == wr0);
    rd1      <= nxt1;
    f_dout1  <= mem1[12'(nxt1)];
    f_empty1 <= (nxt1 == wr1);
  end

  int n_checks = 0, n_errors = 0;
  int exp_ptr0 = 0, idx0 = 0, mpkt0 = 0, cyc = 0;
  int exp_ptr1 = 0, cnt1 = 0;
  int pop_cyc[$];
  int pop1[$];
  logic         pv_valid = 1'b0, pv_ready = 1'b0, pv_sop = 1'b0, pv_eop = 1'b0;
  logic [W-1:0] pv_data  = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_true(input string name, input logic cond);
    check(name, 32'(cond), 32'd1);
  endtask

  task automatic push0(input logic [W-1:0] x);
    mem0[12'(wr0)] = x;
    wr0++;
  endtask

  task automatic push1(input logic [W-1:0] x);
    mem1[12'(wr1)] = x;
    wr1++;
  endtask

  // Stream model for instance 0: words leave in FIFO order, every PL-th word is SOP/EOP.
  task automatic checker0();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (rd_en) begin
          check("no_underflow0", 32'(f_empty), 32'd0);
          if (!f_empty) pop_cyc.push_back(cyc);
        end
        if (pv_valid && !pv_ready) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(pv_data));
          check("hold_sop", 32'(m_sop), 32'(pv_sop));
          check("hold_eop", 32'(m_eop), 32'(pv_eop));
        end
        if (m_valid && m_ready) begin
          expect_true("word_expected", exp_ptr0 < wr0);
          check("stream_data", 32'(m_data), 32'(mem0[12'(exp_ptr0)]));
          check("stream_sop", 32'(m_sop), 32'((idx0 % PL) == 0));
          check("stream_eop", 32'(m_eop), 32'((idx0 % PL) == PL - 1));
          if ((idx0 % PL) == PL - 1) mpkt0++;
          idx0++;
          exp_ptr0++;
        end
        pv_valid = m_valid; pv_ready = m_ready; pv_data = m_data;
        pv_sop   = m_sop;   pv_eop   = m_eop;
      end else begin
        pv_valid = 1'b0;
      end
      @(negedge clk);
      if (rst_n) check("pkt_cnt0", 32'(pkt_cnt), 32'(mpkt0 & 32'hFFFF));
    end
  endtask

  // Single-word packets: every word is both SOP and EOP.
  task automatic checker1();
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (rd_en1) begin
          check("no_underflow1", 32'(f_empty1), 32'd0);
          if (!f_empty1) pop1.push_back(cyc);
        end
        if (m_valid1 && m_ready1) begin
          check("p1_data", 32'(m_data1), 32'(mem1[12'(exp_ptr1)]));
          check("p1_sop", 32'(m_sop1), 32'd1);
          check("p1_eop", 32'(m_eop1), 32'd1);
          exp_ptr1++;
          cnt1++;
        end
      end
      @(negedge clk);
      if (rst_n) check("pkt_cnt1", 32'(pkt_cnt1), 32'(cnt1));
    end
  endtask

  task automatic reset_with(input int n0, input logic [W-1:0] base0,
                            input int n1, input logic [W-1:0] base1, input logic rdy);
    @(negedge clk);
    rst_n   = 1'b0;
    m_ready = rdy;
    for (int i = 0; i < n0; i++) push0(base0 + W'(i));
    for (int i = 0; i < n1; i++) push1(base1 + W'(i));
    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_pkt", 32'(pkt_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    exp_ptr0 = rd0; idx0 = 0; mpkt0 = 0; pv_valid = 1'b0; pop_cyc.delete();
    exp_ptr1 = rd1; cnt1 = 0; pop1.delete();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         rd;
    logic         vld;
    logic [W-1:0] data;
    logic         sop;
    logic         eop;
    logic         bsy;
    logic [15:0]  pkt;
  } vec_t;
  vec_t tbl [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      checker0();
      checker1();
    join_none

    // Clean 16-word packet, cycle by cycle after reset release.
    for (int k = 1; k <= 19; k++) begin
      tbl[k-1].rd   = (k <= 16);
      tbl[k-1].vld  = (k >= 2 && k <= 17);
      tbl[k-1].data = W'(k - 1);
      tbl[k-1].sop  = (k == 2);
      tbl[k-1].eop  = (k == 17);
      tbl[k-1].bsy  = (k <= 18);
      tbl[k-1].pkt  = (k >= 18) ? 16'd1 : 16'd0;
    end
    reset_with(16, 14'h0001, 0, '0, 1'b1);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      check($sformatf("t1_rd[%0d]", k + 1), 32'(rd_en), 32'(tbl[k].rd));
      check($sformatf("t1_vld[%0d]", k + 1), 32'(m_valid), 32'(tbl[k].vld));
      check($sformatf("t1_busy[%0d]", k + 1), 32'(busy), 32'(tbl[k].bsy));
      check($sformatf("t1_pkt[%0d]", k + 1), 32'(pkt_cnt), 32'(tbl[k].pkt));
      if (tbl[k].vld) begin
        check($sformatf("t1_data[%0d]", k + 1), 32'(m_data), 32'(tbl[k].data));
        check($sformatf("t1_sop[%0d]", k + 1), 32'(m_sop), 32'(tbl[k].sop));
        check($sformatf("t1_eop[%0d]", k + 1), 32'(m_eop), 32'(tbl[k].eop));
      end
    end

    // 40 words: two full packets separated by GAP+1 idle cycles, 8 left stalled.
    reset_with(40, 14'h0100, 0, '0, 1'b1);
    for (int i = 0; i < 200 && idx0 < 40; i++) @(negedge clk);
    check("t2_words", idx0, 40);
    repeat (2) @(negedge clk);
    check("t2_pkt", 32'(pkt_cnt), 32'd2);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_rd", 32'(rd_en), 32'd0);
    check("t2_valid", 32'(m_valid), 32'd0);
    check("t2_pops", pop_cyc.size(), 40);
    if (pop_cyc.size() == 40) begin
      check("t2_burst", pop_cyc[15] - pop_cyc[0], 15);
      check("t2_gap1", pop_cyc[16] - pop_cyc[15], GP + 2);
      check("t2_gap2", pop_cyc[32] - pop_cyc[31], GP + 2);
    end

    // Backpressure on the first word.
    reset_with(4, 14'h00A5, 0, '0, 1'b0);
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    expect_true("t3_first_valid", m_valid);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(m_valid), 32'd1);
      check("t3_hold_data", 32'(m_data), 32'h00A5);
      check("t3_no_pop", 32'(rd_en), 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    #1;
    check("t3_pop_on_ready", 32'(rd_en), 32'd1);
    @(negedge clk);
    check("t3_next_data", 32'(m_data), 32'h00A6);
    check("t3_next_valid", 32'(m_valid), 32'd1);
    repeat (6) @(negedge clk);
    check("t3_words", idx0, 4);

    // FIFO runs dry after word 7, then refills.
    reset_with(7, 14'h0200, 0, '0, 1'b1);
    for (int i = 0; i < 30 && pop_cyc.size() < 7; i++) @(negedge clk);
    check("t4_pops7", pop_cyc.size(), 7);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t4_stall_rd", 32'(rd_en), 32'd0);
      check("t4_stall_busy", 32'(busy), 32'd1);
      check("t4_stall_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
    end
    for (int i = 7; i < 16; i++) push0(14'h0200 + W'(i));
    for (int i = 0; i < 40 && idx0 < 16; i++) @(negedge clk);
    check("t4_words", idx0, 16);
    @(negedge clk);
    check("t4_pkt", 32'(pkt_cnt), 32'd1);

    // Asynchronous reset at word 9 of the second packet.
    reset_with(30, 14'h0300, 0, '0, 1'b1);
    for (int i = 0; i < 60 && !(m_valid && m_data == 14'h0318); i++) @(negedge clk);
    expect_true("t5_reach_word9", m_valid && m_data == 14'h0318);
    check("t5_pkt_before", 32'(pkt_cnt), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rd", 32'(rd_en), 32'd0);
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_data", 32'(m_data), 32'd0);
    check("t5_sop", 32'(m_sop), 32'd0);
    check("t5_eop", 32'(m_eop), 32'd0);
    check("t5_pkt", 32'(pkt_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    exp_ptr0 = rd0; idx0 = 0; mpkt0 = 0; pv_valid = 1'b0; pop_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    expect_true("t5_resume_valid", m_valid);
    check("t5_resume_sop", 32'(m_sop), 32'd1);
    check("t5_resume_pkt", 32'(pkt_cnt), 32'd0);
    repeat (12) @(negedge clk);

    // PKT_LEN=1, GAP=0 instance: one idle cycle between single-word packets.
    reset_with(0, '0, 3, 14'h0050, 1'b1);
    for (int i = 0; i < 30 && cnt1 < 3; i++) @(negedge clk);
    check("t6_words", cnt1, 3);
    check("t6_pkt", 32'(pkt_cnt1), 32'd3);
    check("t6_pops", pop1.size(), 3);
    if (pop1.size() == 3) begin
      check("t6_spacing1", pop1[1] - pop1[0], 2);
      check("t6_spacing2", pop1[2] - pop1[1], 2);
    end

    // Randomised traffic and backpressure against the stream model.
    reset_with(0, '0, 0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) push0(W'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 3000 && exp_ptr0 < wr0; i++) @(negedge clk);
    check("t7_drained", exp_ptr0, wr0);
    check("t7_pkt_total", 32'(pkt_cnt), 32'((idx0 / PL) & 32'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
